mmio_bus_ctrl: RTL and testbench

MMIO_BUS_CTRL -- requirements
Module: mmio_bus_ctrl

---
 rtl/mmio_defs.sv | 24 ++
 rtl/io_wait_timer.sv | 44 ++++
 rtl/mmio_bus_ctrl.sv | 178 +++++++++++++++++
 tb/tb_mmio_bus_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_defs.sv
// mmio_defs: shared definitions for the MMIO bus controller.
// Holds the address region codes, the config/status address offsets and the
// IO access FSM state encoding used by mmio_bus_ctrl and its testbench.
package mmio_defs;

  // cpu_addr[31:28] region codes; 0x0-0x7 are all data RAM
  localparam logic [3:0] RGN_VRAM = 4'h8;
  localparam logic [3:0] RGN_IO   = 4'hC;
  localparam logic [3:0] RGN_CFG  = 4'hF;

  // offset of the status word (sticky err) inside the config region
  localparam logic [27:0] CFG_STATUS_OFS = 28'h000_0100;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } bus_state_t;

  function automatic logic is_ram_rgn(input logic [3:0] rgn);
    return !rgn[3];
  endfunction

endpackage

// File: rtl/io_wait_timer.sv
// io_wait_timer: wait-state and timeout counting for the active IO access.
// Ports:
//   clk, clr      - clock, synchronous active-high reset
//   load          - start of an access; loads both counters
//   wait_cycles   - wait states for the addressed channel (CFG value)
//   active        - high while the access is in progress
//   ready         - io_ready of the latched channel
//   done          - access completes this cycle (wait expired and ready)
//   timeout       - access has run TMO cycles without completing
module io_wait_timer #(
  parameter int TMO = 255
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       load,
  input  logic [3:0] wait_cycles,
  input  logic       active,
  input  logic       ready,
  output logic       done,
  output logic       timeout
);

  logic [3:0] wait_cnt;
  logic [7:0] tmo_cnt;

  always_ff @(posedge clk) begin
    if (clr) begin
      wait_cnt <= '0;
      tmo_cnt  <= '0;
    end else if (load) begin
      wait_cnt <= wait_cycles;
      // tmo_cnt reaches 0 in the TMO-th active cycle
      tmo_cnt  <= 8'(TMO - 1);
    end else if (active) begin
      if (wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
      if (tmo_cnt != 8'd0)  tmo_cnt  <= tmo_cnt - 8'd1;
    end
  end

  assign done    = active && (wait_cnt == 4'd0) && ready;
  // a completion in the final allowed cycle wins over the timeout
  assign timeout = active && (tmo_cnt == 8'd0) && !done;

endmodule

// File: rtl/mmio_bus_ctrl.sv
// mmio_bus_ctrl: CPU data-side address decoder and IO access sequencer.
// RAM and VRAM are served combinationally; IO channel accesses run through a
// small FSM with per-channel wait states (CFG) and a timeout that sets err.
// Ports:
//   clk, clr                       - clock, synchronous active-high reset
//   cpu_addr/wdata/re/we           - CPU request
//   cpu_rdata, cpu_stall           - CPU response / hold
//   mem_rdata, mem_we              - data RAM
//   vram_rdata, rvram, wvram       - video RAM
//   io_sel, io_rdn, io_wrn,
//   io_wdata, io_rdata, io_ready   - IO channels (strobes active low)
//   err                            - sticky IO timeout flag
//
// state     | meaning
// ST_IDLE   | decode CPU request; IO request stalls and latches
// ST_ACCESS | IO strobe asserted, waiting for wait states + ready or timeout
// ST_DONE   | strobes released, captured read data returned, CPU released
module mmio_bus_ctrl #(
  parameter int NCH = 4,
  parameter int TMO = 255
) (
  input  logic            clk,
  input  logic            clr,
  input  logic [31:0]     cpu_addr,
  input  logic [31:0]     cpu_wdata,
  input  logic            cpu_re,
  input  logic            cpu_we,
  output logic [31:0]     cpu_rdata,
  output logic            cpu_stall,
  input  logic [31:0]     mem_rdata,
  output logic            mem_we,
  input  logic [31:0]     vram_rdata,
  output logic            rvram,
  output logic            wvram,
  output logic [NCH-1:0]  io_sel,
  output logic            io_rdn,
  output logic            io_wrn,
  output logic [31:0]     io_wdata,
  input  logic [NCH*32-1:0] io_rdata,
  input  logic [NCH-1:0]  io_ready,
  output logic            err
);
  import mmio_defs::*;

  bus_state_t  state;
  logic [3:0]  cfg [NCH];
  logic [2:0]  ch_q;
  logic        wr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;

  logic [3:0]  region;
  logic        is_ram, is_vram, is_io, is_cfg;
  logic        idle, in_access;
  logic [2:0]  ch_req;
  logic        io_req;
  logic        cfg_hit, stat_hit;
  logic [2:0]  cfg_idx;
  logic [3:0]  cfg_rd, cfg_ch;
  logic        ready_sel;
  logic [31:0] rdata_sel;
  logic        tmr_done, tmr_timeout;

  assign region    = cpu_addr[31:28];
  assign is_ram    = is_ram_rgn(region);
  assign is_vram   = (region == RGN_VRAM);
  assign is_io     = (region == RGN_IO);
  assign is_cfg    = (region == RGN_CFG);
  assign idle      = (state == ST_IDLE);
  assign in_access = (state == ST_ACCESS);

  assign ch_req  = cpu_addr[10:8];
  assign io_req  = is_io && (cpu_re || cpu_we) && ({29'd0, ch_req} < 32'(NCH));

  // CFG[k] lives at word k of the config region; everything else there is
  // the status word or unmapped
  assign cfg_hit  = is_cfg && (cpu_addr[27:5] == '0) && (cpu_addr[1:0] == 2'b00);
  assign cfg_idx  = cpu_addr[4:2];
  assign stat_hit = is_cfg && (cpu_addr[27:0] == CFG_STATUS_OFS);

  always_comb begin
    cfg_rd    = '0;
    cfg_ch    = '0;
    ready_sel = 1'b0;
    rdata_sel = '0;
    for (int k = 0; k < NCH; k++) begin
      if (cfg_hit && cfg_idx == 3'(k)) cfg_rd = cfg[k];
      if (ch_req == 3'(k))             cfg_ch = cfg[k];
      if (ch_q == 3'(k)) begin
        ready_sel = io_ready[k];
        rdata_sel = io_rdata[32*k +: 32];
      end
    end
  end

  // RAM/VRAM strobes only in IDLE so a stalled or finishing IO access never
  // leaks a memory write
  assign mem_we = !clr && idle && is_ram  && cpu_we;
  assign wvram  = !clr && idle && is_vram && cpu_we;
  assign rvram  = !clr && idle && is_vram && cpu_re;

  assign cpu_stall = !clr && ((idle && io_req) || in_access);
  assign io_wdata  = wdata_q;

  always_comb begin
    cpu_rdata = '0;
    if (!clr) begin
      case (state)
        ST_IDLE: begin
          if (is_ram)        cpu_rdata = mem_rdata;
          else if (is_vram)  cpu_rdata = vram_rdata;
          else if (stat_hit) cpu_rdata = {31'd0, err};
          else if (cfg_hit)  cpu_rdata = {28'd0, cfg_rd};
        end
        ST_DONE: cpu_rdata = rdata_q;
        default: cpu_rdata = '0;
      endcase
    end
  end

  io_wait_timer #(.TMO(TMO)) u_timer (
    .clk         (clk),
    .clr         (clr),
    .load        (idle && io_req),
    .wait_cycles (cfg_ch),
    .active      (in_access),
    .ready       (ready_sel),
    .done        (tmr_done),
    .timeout     (tmr_timeout)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      state   <= ST_IDLE;
      ch_q    <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      err     <= 1'b0;
      io_sel  <= '0;
      io_rdn  <= 1'b1;
      io_wrn  <= 1'b1;
      for (int k = 0; k < NCH; k++) cfg[k] <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cpu_we && cfg_hit)
            for (int k = 0; k < NCH; k++)
              if (cfg_idx == 3'(k)) cfg[k] <= cpu_wdata[3:0];
          if (cpu_we && stat_hit && cpu_wdata[0]) err <= 1'b0;
          if (io_req) begin
            ch_q    <= ch_req;
            wr_q    <= cpu_we;
            wdata_q <= cpu_wdata;
            for (int k = 0; k < NCH; k++) io_sel[k] <= (ch_req == 3'(k));
            // write takes precedence if the CPU asserts both
            io_rdn  <= cpu_we;
            io_wrn  <= !cpu_we;
            state   <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (tmr_done || tmr_timeout) begin
            rdata_q <= (tmr_done && !wr_q) ? rdata_sel : 32'd0;
            if (tmr_timeout) err <= 1'b1;
            io_sel  <= '0;
            io_rdn  <= 1'b1;
            io_wrn  <= 1'b1;
            state   <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_bus_ctrl.sv
// tb_mmio_bus_ctrl: directed self-checking bench for mmio_bus_ctrl
// (NCH=4, TMO=255). Inputs change 1 time unit after the rising edge and
// outputs are sampled 2 units after it.
module tb_mmio_bus_ctrl;
  localparam int NCH = 4;

  logic              clk = 1'b0;
  logic              clr;
  logic [31:0]       cpu_addr, cpu_wdata;
  logic              cpu_re, cpu_we;
  logic [31:0]       cpu_rdata;
  logic              cpu_stall;
  logic [31:0]       mem_rdata;
  logic              mem_we;
  logic [31:0]       vram_rdata;
  logic              rvram, wvram;
  logic [NCH-1:0]    io_sel;
  logic              io_rdn, io_wrn;
  logic [31:0]       io_wdata;
  logic [NCH*32-1:0] io_rdata;
  logic [NCH-1:0]    io_ready;
  logic              err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mmio_bus_ctrl #(.NCH(NCH), .TMO(255)) dut (
    .clk(clk), .clr(clr),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_re(cpu_re), .cpu_we(cpu_we),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .mem_rdata(mem_rdata), .mem_we(mem_we),
    .vram_rdata(vram_rdata), .rvram(rvram), .wvram(wvram),
    .io_sel(io_sel), .io_rdn(io_rdn), .io_wrn(io_wrn), .io_wdata(io_wdata),
    .io_rdata(io_rdata), .io_ready(io_ready), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [31:0] a, input logic [31:0] d);
    cpu_addr = a; cpu_wdata = d; cpu_we = 1'b1; cpu_re = 1'b0;
    tick();
    cpu_we = 1'b0;
  endtask

  task automatic cpu_read_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    cpu_addr = a; cpu_re = 1'b1; cpu_we = 1'b0;
    #1;
    chk(tag, cpu_rdata, exp);
    chk({tag, "_stall"}, {31'd0, cpu_stall}, 32'd0);
    cpu_re = 1'b0;
    #1;
  endtask

  // Runs one IO request, altering the CPU request in the first ACCESS cycle
  // to show the latched values govern the access. Returns to IDLE afterwards.
  task automatic io_xfer(input logic [31:0] a, input logic we, input logic [31:0] wd,
                         output int stall_n, output int rdn_n, output int wrn_n,
                         output logic [NCH-1:0] sel_seen, output logic [31:0] wd_seen,
                         output logic [31:0] rd);
    logic fin;
    cpu_addr = a; cpu_we = we; cpu_re = !we; cpu_wdata = wd;
    stall_n = 0; rdn_n = 0; wrn_n = 0; sel_seen = '0; wd_seen = '0; rd = '0; fin = 1'b0;
    #1;
    for (int i = 0; i < 400 && !fin; i++) begin
      if (i == 1) begin
        cpu_addr  = a ^ 32'h0000_0100;
        cpu_wdata = ~wd;
        #1;
      end
      if (!io_rdn) rdn_n++;
      if (!io_wrn) begin wrn_n++; wd_seen = io_wdata; end
      sel_seen = sel_seen | io_sel;
      if (cpu_stall) begin
        stall_n++;
        @(posedge clk);
        #2;
      end else begin
        rd  = cpu_rdata;
        fin = 1'b1;
      end
    end
    chk("xfer_finished", {31'd0, fin}, 32'd1);
    cpu_re = 1'b0; cpu_we = 1'b0;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int sn, rn, wn;
    logic [NCH-1:0] sel;
    logic [31:0] wds, rdv;

    clr = 1'b1;
    cpu_addr = 32'h0000_0010; cpu_wdata = 32'h1; cpu_re = 1'b1; cpu_we = 1'b1;
    mem_rdata = 32'hDEAD_0001; vram_rdata = 32'hBEEF_0002;
    io_rdata = '0;
    io_rdata[31:0]  = 32'h1234_5678;
    io_rdata[63:32] = 32'h0BAD_F00D;
    io_rdata[95:64] = 32'hCAFE_0002;
    io_ready = '1;
    repeat (2) tick();
    #1;
    chk("rst_stall", {31'd0, cpu_stall}, 32'd0);
    chk("rst_rdn",   {31'd0, io_rdn}, 32'd1);
    chk("rst_wrn",   {31'd0, io_wrn}, 32'd1);
    chk("rst_sel",   32'(io_sel), 32'd0);
    chk("rst_mem_we",{31'd0, mem_we}, 32'd0);
    chk("rst_rdata", cpu_rdata, 32'd0);
    chk("rst_err",   {31'd0, err}, 32'd0);
    clr = 1'b0; cpu_re = 1'b0; cpu_we = 1'b0;
    tick();
    cpu_read_chk("rst_cfg0", 32'hF000_0000, 32'd0);

    // IO read, zero wait states
    io_xfer(32'hC000_0000, 1'b0, 32'd0, sn, rn, wn, sel, wds, rdv);
    chk("rd0_stall",  32'(sn), 32'd2);
    chk("rd0_rdn",    32'(rn), 32'd1);
    chk("rd0_wrn",    32'(wn), 32'd0);
    chk("rd0_sel",    32'(sel), 32'h1);
    chk("rd0_rdata",  rdv, 32'h1234_5678);

    // CFG[2]=3, write to channel 2
    cpu_write(32'hF000_0008, 32'h3);
    cpu_read_chk("cfg2_rd", 32'hF000_0008, 32'h3);
    cpu_write(32'hF000_0010, 32'h7);
    cpu_read_chk("cfg_oob", 32'hF000_0010, 32'h0);
    io_xfer(32'hC000_0200, 1'b1, 32'h0000_00A5, sn, rn, wn, sel, wds, rdv);
    chk("wr2_stall",  32'(sn), 32'd5);
    chk("wr2_wrn",    32'(wn), 32'd4);
    chk("wr2_rdn",    32'(rn), 32'd0);
    chk("wr2_sel",    32'(sel), 32'h4);
    chk("wr2_wdata",  wds, 32'h0000_00A5);

    // timeout on channel 1
    io_ready = 4'b1101;
    io_xfer(32'hC000_0100, 1'b0, 32'd0, sn, rn, wn, sel, wds, rdv);
    chk("tmo_stall",  32'(sn), 32'd256);
    chk("tmo_rdn",    32'(rn), 32'd255);
    chk("tmo_sel",    32'(sel), 32'h2);
    chk("tmo_rdata",  rdv, 32'd0);
    chk("tmo_err",    {31'd0, err}, 32'd1);
    cpu_read_chk("stat_set", 32'hF000_0100, 32'd1);
    cpu_write(32'hF000_0100, 32'd1);
    chk("err_clr",    {31'd0, err}, 32'd0);
    cpu_read_chk("stat_clr", 32'hF000_0100, 32'd0);
    io_ready = '1;

    // RAM / VRAM
    cpu_addr = 32'h0000_0010; cpu_wdata = 32'h55; cpu_we = 1'b1; #1;
    chk("sw_ram_we",    {31'd0, mem_we}, 32'd1);
    chk("sw_ram_wvram", {31'd0, wvram}, 32'd0);
    chk("sw_ram_stall", {31'd0, cpu_stall}, 32'd0);
    tick();
    cpu_addr = 32'h8000_0004; #1;
    chk("sw_vram_we",   {31'd0, wvram}, 32'd1);
    chk("sw_vram_mem",  {31'd0, mem_we}, 32'd0);
    chk("sw_vram_stall",{31'd0, cpu_stall}, 32'd0);
    tick();
    cpu_we = 1'b0; cpu_re = 1'b1; #1;
    chk("lw_vram_r",    {31'd0, rvram}, 32'd1);
    chk("lw_vram_data", cpu_rdata, 32'hBEEF_0002);
    cpu_addr = 32'h3000_0000; #1;
    chk("lw_ram_data",  cpu_rdata, 32'hDEAD_0001);
    chk("lw_ram_rvram", {31'd0, rvram}, 32'd0);
    cpu_addr = 32'h9000_0000; cpu_we = 1'b1; #1;
    chk("unmap_rdata",  cpu_rdata, 32'd0);
    chk("unmap_we",     {30'd0, mem_we, wvram}, 32'd0);
    chk("unmap_stall",  {31'd0, cpu_stall}, 32'd0);
    cpu_we = 1'b0; cpu_re = 1'b0;
    tick();

    // clr in the second ACCESS cycle
    cpu_write(32'hF000_0000, 32'h3);
    cpu_addr = 32'hC000_0000; cpu_re = 1'b1;
    tick();
    chk("ab_acc1_rdn", {31'd0, io_rdn}, 32'd0);
    tick();
    chk("ab_acc2_rdn", {31'd0, io_rdn}, 32'd0);
    clr = 1'b1; #1;
    chk("ab_clr_stall", {31'd0, cpu_stall}, 32'd0);
    tick();
    clr = 1'b0; cpu_re = 1'b0; #1;
    chk("ab_rdn",   {31'd0, io_rdn}, 32'd1);
    chk("ab_wrn",   {31'd0, io_wrn}, 32'd1);
    chk("ab_sel",   32'(io_sel), 32'd0);
    chk("ab_err",   {31'd0, err}, 32'd0);
    chk("ab_stall", {31'd0, cpu_stall}, 32'd0);
    cpu_read_chk("ab_cfg0", 32'hF000_0000, 32'd0);
    cpu_read_chk("ab_cfg2", 32'hF000_0008, 32'd0);
    io_xfer(32'hC000_0000, 1'b0, 32'd0, sn, rn, wn, sel, wds, rdv);
    chk("ab_next_stall", 32'(sn), 32'd2);
    chk("ab_next_rdata", rdv, 32'h1234_5678);

    // unmapped channel 7
    io_xfer(32'hC000_0700, 1'b0, 32'd0, sn, rn, wn, sel, wds, rdv);
    chk("ch7_stall", 32'(sn), 32'd0);
    chk("ch7_strb",  32'(rn + wn), 32'd0);
    chk("ch7_sel",   32'(sel), 32'd0);
    chk("ch7_rdata", rdv, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
